// File: rtl/eth_chk_pkg.sv
// Shared types for the receive-side counting-pattern frame checker.
package eth_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IN_FRAME,
        OVERRUN
    } state_t;

    typedef struct packed {
        logic tuser;
        logic long_len;
        logic short_len;
        logic data;
    } frame_err_t;

    localparam int ERR_DATA  = 0;
    localparam int ERR_SHORT = 1;
    localparam int ERR_LONG  = 2;
    localparam int ERR_TUSER = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clr zeroes it and a same-cycle inc then counts from zero.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic [W-1:0] base;

    always_comb begin
        base = clr ? '0 : q_q;
        q_d  = base;
        if (inc && (base != '1)) begin
            q_d = base + W'(1);
        end
    end

    // NOTE: sequential state is only ever written with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/eth_rx_frame_checker.sv
// Checks received frames against the START_VALUE, START_VALUE+1, ... counting
// pattern and keeps statistics, sticky error flags and a first-mismatch capture.
module eth_rx_frame_checker
    import eth_chk_pkg::*;
#(
    parameter int         FRAME_LEN   = 256,
    parameter logic [7:0] START_VALUE = 8'd0,
    parameter int         CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_axis_tdata,
    input  logic             rx_axis_tvalid,
    input  logic             rx_axis_tlast,
    input  logic             rx_axis_tuser,
    input  logic             clr,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt,
    output logic [CNT_W-1:0] byte_err_cnt,
    output logic [3:0]       err_sticky,
    output logic             cap_valid,
    output logic [CNT_W-1:0] cap_frame,
    output logic [15:0]      cap_offset,
    output logic [7:0]       cap_exp,
    output logic [7:0]       cap_got
);

    state_t     state_q, state_d;
    logic [15:0] offset_q, offset_d;
    frame_err_t acc_q, acc_d, acc_new;
    logic [3:0] beat_err;
    logic [7:0] exp_byte;
    logic [15:0] beat_offset;
    logic       compare, done, mismatch, ok;

    logic             frame_done_q, frame_done_d;
    logic             frame_ok_q, frame_ok_d;
    logic [3:0]       err_sticky_q, err_sticky_d;
    logic             cap_valid_q, cap_valid_d;
    logic [CNT_W-1:0] cap_frame_q, cap_frame_d;
    logic [15:0]      cap_offset_q, cap_offset_d;
    logic [7:0]       cap_exp_q, cap_exp_d;
    logic [7:0]       cap_got_q, cap_got_d;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        acc_new     = acc_q;
        beat_err    = '0;
        exp_byte    = '0;
        beat_offset = offset_q;
        compare     = 1'b0;
        done        = 1'b0;

        if (rx_axis_tvalid) begin
            unique case (state_q)
                IDLE: begin
                    acc_new     = '0;
                    exp_byte    = START_VALUE;
                    beat_offset = '0;
                    compare     = 1'b1;
                    offset_d    = 16'd1;
                    if (rx_axis_tlast) begin
                        done                = 1'b1;
                        beat_err[ERR_SHORT] = 1'b1;
                    end else begin
                        state_d = IN_FRAME;
                    end
                end
                IN_FRAME: begin
                    exp_byte = START_VALUE + offset_q[7:0];
                    compare  = 1'b1;
                    offset_d = offset_q + 16'd1;
                    if (rx_axis_tlast) begin
                        done                = 1'b1;
                        beat_err[ERR_SHORT] = (17'(offset_q) + 17'd1) < 17'(FRAME_LEN);
                    end else if (offset_q == 16'(FRAME_LEN - 1)) begin
                        beat_err[ERR_LONG] = 1'b1;
                        state_d            = OVERRUN;
                    end
                end
                OVERRUN: begin
                    done = rx_axis_tlast;
                end
                default: state_d = IDLE;
            endcase
            beat_err[ERR_DATA]  = compare && (rx_axis_tdata != exp_byte);
            beat_err[ERR_TUSER] = rx_axis_tlast && rx_axis_tuser;
        end

        acc_new = acc_new | frame_err_t'(beat_err);
        acc_d   = acc_new;
        if (done) begin
            state_d = IDLE;
        end
    end

    assign mismatch = beat_err[ERR_DATA];
    assign ok       = (acc_new == '0);

    // clr wipes history first; the current beat's contribution is then applied.
    always_comb begin
        frame_done_d = done;
        frame_ok_d   = done && ok;
        err_sticky_d = (clr ? 4'd0 : err_sticky_q) | (done ? 4'(acc_new) : 4'd0);

        cap_valid_d  = clr ? 1'b0 : cap_valid_q;
        cap_frame_d  = clr ? '0 : cap_frame_q;
        cap_offset_d = clr ? '0 : cap_offset_q;
        cap_exp_d    = clr ? '0 : cap_exp_q;
        cap_got_d    = clr ? '0 : cap_got_q;
        if (mismatch && !cap_valid_d) begin
            cap_valid_d  = 1'b1;
            cap_frame_d  = clr ? '0 : frame_cnt;
            cap_offset_d = beat_offset;
            cap_exp_d    = exp_byte;
            cap_got_d    = rx_axis_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            offset_q     <= '0;
            acc_q        <= '0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            err_sticky_q <= '0;
            cap_valid_q  <= 1'b0;
            cap_frame_q  <= '0;
            cap_offset_q <= '0;
            cap_exp_q    <= '0;
            cap_got_q    <= '0;
        end else begin
            state_q      <= state_d;
            offset_q     <= offset_d;
            acc_q        <= acc_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            err_sticky_q <= err_sticky_d;
            cap_valid_q  <= cap_valid_d;
            cap_frame_q  <= cap_frame_d;
            cap_offset_q <= cap_offset_d;
            cap_exp_q    <= cap_exp_d;
            cap_got_q    <= cap_got_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_frame_cnt (
        .clk(clk), .rst(rst), .clr(clr), .inc(done), .q(frame_cnt)
    );
    sat_counter #(.W(CNT_W)) u_good_cnt (
        .clk(clk), .rst(rst), .clr(clr), .inc(done && ok), .q(good_cnt)
    );
    sat_counter #(.W(CNT_W)) u_bad_cnt (
        .clk(clk), .rst(rst), .clr(clr), .inc(done && !ok), .q(bad_cnt)
    );
    sat_counter #(.W(CNT_W)) u_byte_err_cnt (
        .clk(clk), .rst(rst), .clr(clr), .inc(mismatch), .q(byte_err_cnt)
    );

    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign err_sticky = err_sticky_q;
    assign cap_valid  = cap_valid_q;
    assign cap_frame  = cap_frame_q;
    assign cap_offset = cap_offset_q;
    assign cap_exp    = cap_exp_q;
    assign cap_got    = cap_got_q;

endmodule

// File: tb/tb_eth_rx_frame_checker.sv
// Scoreboard bench: expected per-frame results are queued with the stimulus and
// popped by monitors on each frame_done pulse.
module tb_eth_rx_frame_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tdata = '0;
    logic       tvalid = 1'b0;
    logic       tlast = 1'b0;
    logic       tuser = 1'b0;
    logic       clr = 1'b0;
    logic       sel2 = 1'b0;
    logic       v1, v2;

    always #5 clk = ~clk;

    assign v1 = tvalid & ~sel2;
    assign v2 = tvalid & sel2;

    logic        d1_done, d1_ok, d1_capv;
    logic [31:0] d1_fc, d1_gc, d1_bc, d1_bec, d1_capf;
    logic [3:0]  d1_st;
    logic [15:0] d1_capo;
    logic [7:0]  d1_cape, d1_capg;

    logic        d2_done, d2_ok, d2_capv;
    logic [3:0]  d2_fc, d2_gc, d2_bc, d2_bec, d2_capf;
    logic [3:0]  d2_st;
    logic [15:0] d2_capo;
    logic [7:0]  d2_cape, d2_capg;

    eth_rx_frame_checker #(.FRAME_LEN(256), .START_VALUE(8'h00), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .rx_axis_tdata(tdata), .rx_axis_tvalid(v1),
        .rx_axis_tlast(tlast), .rx_axis_tuser(tuser), .clr(clr),
        .frame_done(d1_done), .frame_ok(d1_ok), .frame_cnt(d1_fc), .good_cnt(d1_gc),
        .bad_cnt(d1_bc), .byte_err_cnt(d1_bec), .err_sticky(d1_st),
        .cap_valid(d1_capv), .cap_frame(d1_capf), .cap_offset(d1_capo),
        .cap_exp(d1_cape), .cap_got(d1_capg)
    );

    eth_rx_frame_checker #(.FRAME_LEN(40), .START_VALUE(8'hF0), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .rx_axis_tdata(tdata), .rx_axis_tvalid(v2),
        .rx_axis_tlast(tlast), .rx_axis_tuser(tuser), .clr(clr),
        .frame_done(d2_done), .frame_ok(d2_ok), .frame_cnt(d2_fc), .good_cnt(d2_gc),
        .bad_cnt(d2_bc), .byte_err_cnt(d2_bec), .err_sticky(d2_st),
        .cap_valid(d2_capv), .cap_frame(d2_capf), .cap_offset(d2_capo),
        .cap_exp(d2_cape), .cap_got(d2_capg)
    );

    typedef struct {
        bit         ok;
        int         fc;
        int         gc;
        int         bc;
        int         bec;
        logic [3:0] st;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int   n_vec = 0;
    int   n_mis = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input bit ok, input int fc, input int gc, input int bc,
                                input int bec, input logic [3:0] st);
        exp_t e;
        e.ok = ok; e.fc = fc; e.gc = gc; e.bc = bc; e.bec = bec; e.st = st;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && d1_done) begin
            if (q1.size() == 0) begin
                check("dut unexpected frame_done", 64'd1, 64'd0);
            end else begin
                e1 = q1.pop_front();
                check("dut frame_ok", 64'(d1_ok), 64'(e1.ok));
                check("dut frame_cnt", 64'(d1_fc), 64'(e1.fc));
                check("dut good_cnt", 64'(d1_gc), 64'(e1.gc));
                check("dut bad_cnt", 64'(d1_bc), 64'(e1.bc));
                check("dut byte_err_cnt", 64'(d1_bec), 64'(e1.bec));
                check("dut err_sticky", 64'(d1_st), 64'(e1.st));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && d2_done) begin
            if (q2.size() == 0) begin
                check("small unexpected frame_done", 64'd1, 64'd0);
            end else begin
                e2 = q2.pop_front();
                check("small frame_ok", 64'(d2_ok), 64'(e2.ok));
                check("small frame_cnt", 64'(d2_fc), 64'(e2.fc));
                check("small good_cnt", 64'(d2_gc), 64'(e2.gc));
                check("small bad_cnt", 64'(d2_bc), 64'(e2.bc));
            end
        end
    end

    // Sends pattern bytes first..last_i (bad_idx replaced by bad_val); tlast only if do_last.
    task automatic send_range(input int first, input int last_i, input logic [7:0] start,
                              input bit do_last, input bit user, input bit clr_last,
                              input int gap_max, input int bad_idx, input logic [7:0] bad_val);
        for (int i = first; i <= last_i; i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    tvalid = 1'b0; tlast = 1'b0; clr = 1'b0;
                    @(posedge clk); #1;
                end
            end
            tvalid = 1'b1;
            tdata  = (i == bad_idx) ? bad_val : 8'(int'(start) + i);
            tlast  = do_last && (i == last_i);
            tuser  = tlast ? user : 1'($urandom_range(1, 0));
            clr    = tlast && clr_last;
            @(posedge clk); #1;
        end
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; clr = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset frame_done", 64'(d1_done), 64'd0);
        check("reset frame_cnt", 64'(d1_fc), 64'd0);
        check("reset good_cnt", 64'(d1_gc), 64'd0);
        check("reset err_sticky", 64'(d1_st), 64'd0);
        check("reset cap_valid", 64'(d1_capv), 64'd0);
        @(posedge clk); #1;

        // Two good 256-byte frames back to back.
        q1.push_back(mk(1, 1, 1, 0, 0, 4'b0000));
        q1.push_back(mk(1, 2, 2, 0, 0, 4'b0000));
        send_range(0, 255, 8'h00, 1, 0, 0, 0, -1, 8'h00);
        send_range(0, 255, 8'h00, 1, 0, 0, 0, -1, 8'h00);
        @(posedge clk); #1;

        // Byte 100 corrupted.
        pulse_clr();
        check("clr frame_cnt", 64'(d1_fc), 64'd0);
        q1.push_back(mk(0, 1, 0, 1, 1, 4'b0001));
        send_range(0, 255, 8'h00, 1, 0, 0, 0, 100, 8'hAA);
        @(posedge clk); #1;
        check("cap_valid", 64'(d1_capv), 64'd1);
        check("cap_offset", 64'(d1_capo), 64'd100);
        check("cap_exp", 64'(d1_cape), 64'd100);
        check("cap_got", 64'(d1_capg), 64'hAA);
        check("cap_frame", 64'(d1_capf), 64'd0);

        // Short frame (200 bytes), then long frame (300 bytes).
        pulse_clr();
        check("clr cap_valid", 64'(d1_capv), 64'd0);
        check("clr err_sticky", 64'(d1_st), 64'd0);
        q1.push_back(mk(0, 1, 0, 1, 0, 4'b0010));
        q1.push_back(mk(0, 2, 0, 2, 0, 4'b0110));
        send_range(0, 199, 8'h00, 1, 0, 0, 0, -1, 8'h00);
        send_range(0, 299, 8'h00, 1, 0, 0, 0, -1, 8'h00);
        @(posedge clk); #1;

        // Correct pattern but MAC flags a bad FCS.
        pulse_clr();
        q1.push_back(mk(0, 1, 0, 1, 0, 4'b1000));
        send_range(0, 255, 8'h00, 1, 1, 0, 0, -1, 8'h00);
        @(posedge clk); #1;

        // Ten good frames with random gaps, then clr on the next frame's tlast.
        pulse_clr();
        for (int f = 0; f < 10; f++) begin
            q1.push_back(mk(1, f + 1, f + 1, 0, 0, 4'b0000));
            send_range(0, 255, 8'h00, 1, 0, 0, 3, -1, 8'h00);
        end
        q1.push_back(mk(1, 1, 1, 0, 0, 4'b0000));
        send_range(0, 255, 8'h00, 1, 0, 1, 2, -1, 8'h00);
        @(posedge clk); #1;

        // Reset mid-frame: the tail 100..255 is checked as a new frame.
        send_range(0, 99, 8'h00, 0, 0, 0, 0, -1, 8'h00);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q1.push_back(mk(0, 1, 0, 1, 156, 4'b0011));
        send_range(100, 255, 8'h00, 1, 0, 0, 0, -1, 8'h00);
        @(posedge clk); #1;
        check("rst cap_offset", 64'(d1_capo), 64'd0);
        check("rst cap_got", 64'(d1_capg), 64'd100);

        // Narrow counters saturate; pattern F0.. wraps 255->0 inside each frame.
        sel2 = 1'b1;
        for (int f = 0; f < 20; f++) begin
            q2.push_back(mk(1, (f < 15) ? f + 1 : 15, (f < 15) ? f + 1 : 15, 0, 0, 4'b0000));
            send_range(0, 39, 8'hF0, 1, 0, 0, 1, -1, 8'h00);
        end
        @(posedge clk); #1;
        check("small final frame_cnt", 64'(d2_fc), 64'd15);
        check("small byte_err_cnt", 64'(d2_bec), 64'd0);
        sel2 = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check("dut expected frames all seen", 64'(q1.size()), 64'd0);
        check("small expected frames all seen", 64'(q2.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
